// File: rtl/ft245_pkg.sv
// Shared types and defaults for the FT245 device-side bus model.
package ft245_pkg;

  localparam int FT245_W     = 8;
  localparam int DEF_RD_LAT  = 2;
  localparam int DEF_RECOVER = 1;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DRIVE,
    R_RECOV
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_LOW,
    W_RECOV
  } wr_state_t;

endpackage

// File: rtl/ft245_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; pointers carry one extra wrap bit.
module ft245_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ft245_device_model.sv
// Device end of the FT245 async FIFO bus: read/write strobe FSMs, host stream
// FIFOs in both directions and sticky protocol-error flags.
module ft245_device_model
  import ft245_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int RD_LAT  = DEF_RD_LAT,
  parameter int RECOVER = DEF_RECOVER
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FT245_W-1:0] host_wdata,
  input  logic               host_wvalid,
  output logic               host_wready,
  output logic [FT245_W-1:0] host_rdata,
  output logic               host_rvalid,
  input  logic               host_rready,
  output logic               rxf_n,
  output logic               txe_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [FT245_W-1:0] data_in,
  output logic [FT245_W-1:0] data_out,
  output logic               data_oe,
  output logic               err_rd,
  output logic               err_wr,
  output logic               err_bus
);

  rd_state_t          rd_state_reg, rd_state_next;
  wr_state_t          wr_state_reg, wr_state_next;
  logic [2:0]         rd_cnt_reg, rd_cnt_next;
  logic [2:0]         wr_cnt_reg, wr_cnt_next;
  logic               rxf_n_reg, rxf_n_next;
  logic               txe_n_reg, txe_n_next;
  logic               data_oe_reg, data_oe_next;
  logic [FT245_W-1:0] data_out_reg, data_out_next;
  logic               err_rd_reg, err_rd_next;
  logic               err_wr_reg, err_wr_next;
  logic               err_bus_reg, err_bus_next;
  logic               rd_prev_reg, wr_prev_reg, armed_reg;
  logic               rd_fall, rd_rise, wr_fall, wr_rise;

  logic               rx_push, rx_pop, rx_full, rx_empty;
  logic               tx_push, tx_pop, tx_full, tx_empty;
  logic [FT245_W-1:0] rx_head, tx_head;

  // Edges are suppressed for the first cycle after reset so a strobe held low
  // across reset release is not mistaken for a fresh fall.
  assign rd_fall = armed_reg &&  rd_prev_reg && !rd_n;
  assign rd_rise = armed_reg && !rd_prev_reg &&  rd_n;
  assign wr_fall = armed_reg &&  wr_prev_reg && !wr_n;
  assign wr_rise = armed_reg && !wr_prev_reg &&  wr_n;

  assign host_wready = !rx_full;
  assign rx_push     = host_wvalid && host_wready;
  assign host_rvalid = !tx_empty;
  assign host_rdata  = tx_empty ? '0 : tx_head;
  assign tx_pop      = host_rvalid && host_rready;

  ft245_sync_fifo #(.W(FT245_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(host_wdata),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  ft245_sync_fifo #(.W(FT245_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(data_in),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_cnt_next   = rd_cnt_reg;
    data_oe_next  = data_oe_reg;
    data_out_next = data_out_reg;
    err_rd_next   = err_rd_reg;
    rx_pop        = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        if (rd_fall && !rxf_n_reg && !rx_empty) begin
          data_oe_next  = 1'b1;
          rd_cnt_next   = 3'(RD_LAT - 1);
          rd_state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_rise) begin
          rx_pop        = 1'b1;
          data_oe_next  = 1'b0;
          err_rd_next   = 1'b1;
          rd_cnt_next   = 3'(RECOVER - 1);
          rd_state_next = R_RECOV;
        end else if (rd_cnt_reg == 3'd0) begin
          data_out_next = rx_head;
          rd_state_next = R_DRIVE;
        end else begin
          rd_cnt_next = rd_cnt_reg - 3'd1;
        end
      end
      R_DRIVE: begin
        if (rd_rise) begin
          rx_pop        = 1'b1;
          data_oe_next  = 1'b0;
          rd_cnt_next   = 3'(RECOVER - 1);
          rd_state_next = R_RECOV;
        end
      end
      R_RECOV: begin
        if (rd_cnt_reg == 3'd0) rd_state_next = R_IDLE;
        else                    rd_cnt_next   = rd_cnt_reg - 3'd1;
      end
      default: rd_state_next = R_IDLE;
    endcase
    if (rd_fall && rxf_n_reg) err_rd_next = 1'b1;
    rxf_n_next = (rd_state_next != R_IDLE) || rx_empty;
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_cnt_next   = wr_cnt_reg;
    err_wr_next   = err_wr_reg;
    tx_push       = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        if (wr_fall && !txe_n_reg && !tx_full) begin
          tx_push       = 1'b1;
          wr_state_next = W_LOW;
        end
      end
      W_LOW: begin
        if (wr_rise) begin
          wr_cnt_next   = 3'(RECOVER - 1);
          wr_state_next = W_RECOV;
        end
      end
      W_RECOV: begin
        if (wr_cnt_reg == 3'd0) wr_state_next = W_IDLE;
        else                    wr_cnt_next   = wr_cnt_reg - 3'd1;
      end
      default: wr_state_next = W_IDLE;
    endcase
    if (wr_fall && txe_n_reg) err_wr_next = 1'b1;
    txe_n_next   = (wr_state_next != W_IDLE) || tx_full;
    err_bus_next = err_bus_reg || (data_oe_reg && !wr_n);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_reg <= R_IDLE;
      wr_state_reg <= W_IDLE;
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
      rxf_n_reg    <= 1'b1;
      txe_n_reg    <= 1'b1;
      data_oe_reg  <= 1'b0;
      data_out_reg <= '0;
      err_rd_reg   <= 1'b0;
      err_wr_reg   <= 1'b0;
      err_bus_reg  <= 1'b0;
      rd_prev_reg  <= 1'b1;
      wr_prev_reg  <= 1'b1;
      armed_reg    <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      wr_state_reg <= wr_state_next;
      rd_cnt_reg   <= rd_cnt_next;
      wr_cnt_reg   <= wr_cnt_next;
      rxf_n_reg    <= rxf_n_next;
      txe_n_reg    <= txe_n_next;
      data_oe_reg  <= data_oe_next;
      data_out_reg <= data_out_next;
      err_rd_reg   <= err_rd_next;
      err_wr_reg   <= err_wr_next;
      err_bus_reg  <= err_bus_next;
      rd_prev_reg  <= rd_n;
      wr_prev_reg  <= wr_n;
      armed_reg    <= 1'b1;
    end
  end

  assign rxf_n    = rxf_n_reg;
  assign txe_n    = txe_n_reg;
  assign data_oe  = data_oe_reg;
  assign data_out = data_out_reg;
  assign err_rd   = err_rd_reg;
  assign err_wr   = err_wr_reg;
  assign err_bus  = err_bus_reg;

endmodule

// File: tb/tb_ft245_device_model.sv
// Directed bench for ft245_device_model (DEPTH=16, RD_LAT=2, RECOVER=1).
module tb_ft245_device_model;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] host_wdata;
  logic       host_wvalid;
  logic       host_wready;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       host_rready;
  logic       rxf_n, txe_n;
  logic       rd_n, wr_n;
  logic [7:0] data_in, data_out;
  logic       data_oe;
  logic       err_rd, err_wr, err_bus;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ft245_device_model #(.DEPTH(16), .RD_LAT(2), .RECOVER(1)) dut (
    .clk(clk), .rst(rst),
    .host_wdata(host_wdata), .host_wvalid(host_wvalid), .host_wready(host_wready),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_rready(host_rready),
    .rxf_n(rxf_n), .txe_n(txe_n), .rd_n(rd_n), .wr_n(wr_n),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .err_rd(err_rd), .err_wr(err_wr), .err_bus(err_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic host_push(input logic [7:0] b);
    host_wvalid = 1'b1;
    host_wdata  = b;
    tick();
    host_wvalid = 1'b0;
    $display("host push 0x%02h", b);
  endtask

  // rd_n low for 4 sampled edges; data must appear exactly two edges after the fall.
  task automatic fpga_read(input logic [7:0] exp, input logic [7:0] prev);
    rd_n = 1'b0;
    tick();
    check("rd_oe_on", data_oe, 1'b1);
    tick();
    check("rd_hold_prev", data_out, prev);
    tick();
    check("rd_data", data_out, exp);
    tick();
    rd_n = 1'b1;
    tick();
    check("rd_oe_off", data_oe, 1'b0);
    check("rd_recov_rxf", rxf_n, 1'b1);
    tick();
    $display("fpga read 0x%02h (expected 0x%02h)", data_out, exp);
  endtask

  task automatic fpga_write(input logic [7:0] b);
    data_in = b;
    wr_n    = 1'b0;
    tick();
    wr_n = 1'b1;
    tick();
    tick();
    tick();
    $display("fpga write 0x%02h", b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    host_wvalid = 1'b0; host_wdata = '0; host_rready = 1'b0; data_in = '0;
    repeat (3) tick();
    check("rst_rxf_n", rxf_n, 1'b1);
    check("rst_txe_n", txe_n, 1'b1);
    check("rst_oe", data_oe, 1'b0);
    check("rst_dout", data_out, 8'h00);
    check("rst_rvalid", host_rvalid, 1'b0);
    check("rst_rdata", host_rdata, 8'h00);
    check("rst_errs", {err_rd, err_wr, err_bus}, 3'b000);
    rst = 1'b1;
    repeat (10) tick();
    check("idle_rxf_n", rxf_n, 1'b1);
    check("idle_txe_n", txe_n, 1'b0);
    check("idle_oe", data_oe, 1'b0);
    check("idle_errs", {err_rd, err_wr, err_bus}, 3'b000);
    check("idle_wready", host_wready, 1'b1);

    // Read burst
    host_push(8'hA5);
    host_push(8'h3C);
    check("burst_rxf_low", rxf_n, 1'b0);
    fpga_read(8'hA5, 8'h00);
    check("burst_rxf_after1", rxf_n, 1'b0);
    fpga_read(8'h3C, 8'hA5);
    check("burst_rxf_empty", rxf_n, 1'b1);
    repeat (3) tick();
    check("burst_rxf_stays", rxf_n, 1'b1);
    check("burst_errs", {err_rd, err_wr, err_bus}, 3'b000);

    // Write fill, overflow, drain
    do_reset();
    tick();
    for (int i = 0; i < 16; i++) fpga_write(8'(i));
    check("fill_txe_full", txe_n, 1'b1);
    check("fill_no_err", err_wr, 1'b0);
    data_in = 8'hFF;
    wr_n    = 1'b0;
    tick();
    check("fill_err_wr", err_wr, 1'b1);
    wr_n = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", host_rvalid, 1'b1);
      check("drain_data", host_rdata, 8'(i));
      $display("host pop 0x%02h", host_rdata);
      host_rready = 1'b1;
      tick();
      host_rready = 1'b0;
    end
    check("drain_empty", host_rvalid, 1'b0);
    tick();
    check("drain_txe", txe_n, 1'b0);
    check("drain_err_sticky", err_wr, 1'b1);

    // Protocol errors
    do_reset();
    tick();
    rd_n = 1'b0;
    tick();
    check("err_rd_set", err_rd, 1'b1);
    check("err_rd_no_oe", data_oe, 1'b0);
    rd_n = 1'b1;
    tick();
    tick();
    check("err_rd_no_oe2", data_oe, 1'b0);
    host_push(8'h42);
    tick();
    rd_n = 1'b0;
    tick();
    check("bus_oe_on", data_oe, 1'b1);
    check("bus_clear", err_bus, 1'b0);
    wr_n    = 1'b0;
    data_in = 8'h99;
    tick();
    check("bus_err_set", err_bus, 1'b1);
    wr_n = 1'b1;
    tick();
    check("bus_drive_data", data_out, 8'h42);
    rd_n = 1'b1;
    repeat (3) tick();
    check("bus_err_rd_sticky", err_rd, 1'b1);

    // Concurrency
    do_reset();
    tick();
    for (int i = 0; i < 15; i++) host_push(8'h10 + 8'(i));
    check("conc_wready15", host_wready, 1'b1);
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    data_in = 8'hC3;
    tick();
    wr_n = 1'b1;
    check("conc_oe", data_oe, 1'b1);
    check("conc_tx_valid", host_rvalid, 1'b1);
    check("conc_tx_data", host_rdata, 8'hC3);
    tick();
    tick();
    check("conc_rd_data", data_out, 8'h10);
    tick();
    rd_n        = 1'b1;
    host_wvalid = 1'b1;
    host_wdata  = 8'h80;
    tick();
    host_wvalid = 1'b0;
    check("conc_count15", host_wready, 1'b1);
    host_push(8'h81);
    check("conc_full16", host_wready, 1'b0);
    check("conc_errs", {err_rd, err_wr, err_bus}, 3'b000);

    // Reset while driving
    rd_n = 1'b0;
    tick();
    tick();
    tick();
    check("mid_drive_data", data_out, 8'h11);
    check("mid_drive_oe", data_oe, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_oe", data_oe, 1'b0);
    check("mid_rst_rxf", rxf_n, 1'b1);
    check("mid_rst_dout", data_out, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    tick();
    host_push(8'h77);
    rd_n = 1'b1;
    tick();
    tick();
    check("rel_oe", data_oe, 1'b0);
    check("rel_err_rd", err_rd, 1'b0);
    check("rel_rxf", rxf_n, 1'b0);
    fpga_read(8'h77, 8'h00);
    check("rel_rxf_empty", rxf_n, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ft245_device_model.md
# ft245_device_model

Cycle-accurate, synthesizable model of the FT245 asynchronous USB FIFO chip, i.e. the device end of the FT245 bus. It sits opposite the FPGA-side FT245 controller inside the `test_block_io` bench and in on-board loopback builds. It presents `rxf_n`/`txe_n`, responds to `rd_n`/`wr_n` strobes and drives the split data bus. A stream port on the "USB host" side feeds bytes toward the FPGA and collects bytes written by it.

## Interface
- `DEPTH`, 16: entries per direction FIFO; power of two, ≥ 2.
- `RD_LAT`, 2: cycles from sampled `rd_n` fall to valid `data_out`; range 1–7.
- `RECOVER`, 1: cycles `rxf_n`/`txe_n` stay high after a strobe rises; range 1–7.

Ports:
- `clk` in 1: single clock. All pins are sampled on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `host_wdata` in 8: byte from host, destined for the FPGA.
- `host_wvalid` in 1 / `host_wready` out 1: push handshake into the RX FIFO.
- `host_rdata` out 8: byte written by the FPGA.
- `host_rvalid` out 1 / `host_rready` in 1: pop handshake from the TX FIFO.
- `rxf_n` out 1: low means a byte is available to read.
- `txe_n` out 1: low means a byte may be written.
- `rd_n` in 1, `wr_n` in 1: strobes from the FPGA controller.
- `data_in` in 8: bus value while the FPGA drives.
- `data_out` out 8, `data_oe` out 1: device bus drive, used by the pin-level tristate wrapper.
- `err_rd`, `err_wr`, `err_bus` out 1 each: sticky protocol-error flags.

## Operation
- **Edge detection.** `rd_n` and `wr_n` are synchronous to `clk` and are not resynchronized. A fall is `prev==1 && now==0`; a rise is the opposite. Both `prev` registers reset to 1.
- **RX path** (host → FPGA). A host push happens on `host_wvalid && host_wready`. `host_wready = !rx_full`.
- **Read FSM states:** `R_IDLE`, `R_WAIT`, `R_DRIVE`, `R_RECOV`.
  - `R_IDLE`: `rxf_n = rx_empty`. On an `rd_n` fall with RX non-empty, set `data_oe = 1`, load the counter with `RD_LAT-1`, and go to `R_WAIT`.
  - `R_WAIT`: `data_out` holds the previous value. When the counter reaches 0, set `data_out` to the RX head and go to `R_DRIVE`.
  - On an `rd_n` rise in `R_WAIT` or `R_DRIVE`: pop the RX head, set `data_oe = 0`, and enter `R_RECOV` for `RECOVER` cycles. An early rise in `R_WAIT` still pops and also sets `err_rd`.
  - `rxf_n` is 1 in every state except `R_IDLE`.
  - An `rd_n` fall while `rxf_n == 1` sets `err_rd`. It causes no pop and no drive.
- **TX path** (FPGA → host). `host_rvalid = !tx_empty` and `host_rdata` = TX head. A pop happens on `host_rvalid && host_rready`.
- **Write FSM states:** `W_IDLE`, `W_LOW`, `W_RECOV`.
  - `W_IDLE`: `txe_n = tx_full`. On a `wr_n` fall with TX not full, push `data_in` (the value sampled in the fall cycle) and go to `W_LOW`.
  - `W_LOW` waits for a `wr_n` rise, then enters `W_RECOV` for `RECOVER` cycles, then returns to `W_IDLE`.
  - A `wr_n` fall while `txe_n == 1` sets `err_wr`; the byte is discarded.
- **Concurrency.** Host push and FPGA read of the same FIFO in one cycle are both honoured, and the same holds for TX. A push into an empty RX makes `rxf_n` fall in the following cycle.
- **Bus contention.** `err_bus` sets whenever `data_oe && !wr_n`.
- **Error flags.** They clear only on reset.

## Timing
- **Reset values:** `rxf_n = 1`, `txe_n = 1`, `data_oe = 0`, `data_out = 0`, `host_rvalid = 0`, `host_rdata = 0`, all `err_* = 0`, FSMs in IDLE, FIFOs empty. `host_wready` becomes 1 combinationally after reset.
- **Registered outputs:** `rxf_n`, `txe_n`, `data_oe`, `data_out`, `err_*`. FIFO-derived ready/valid are combinational from the FIFO flags.
- **Read latency:** `rd_n` falls at edge N → `data_oe = 1` after edge N → `data_out` valid after edge N+`RD_LAT`.
- **Write:** `wr_n` falls at edge N → byte is in the TX FIFO after N → `host_rvalid` rises after N if TX was empty.
- **Reset mid-strobe:** outputs go to reset values immediately. A strobe still low when reset releases produces no fall edge, so it is ignored.
- **FIFO pointers:** `log2(DEPTH)+1` bits; wrap-around is on the extra bit. Full means the MSBs differ and the lower bits are equal.

## Structure
- Package `ft245_pkg`:
  - read-state and write-state enums;
  - `FT245_W = 8`;
  - default `RD_LAT` and `RECOVER` constants.
- Sub-module `ft245_sync_fifo`, instantiated twice (RX and TX). It has a parameterized width and depth, exposes push/pop/full/empty/head, and uses a first-word-fall-through head.
- The top level contains the two FSMs, edge detection and error flags.

## Test plan
- **Reset/idle.** Hold `rst = 0`, release it, idle 10 cycles → `rxf_n = 1`, `txe_n = 0`, `data_oe = 0`, all `err_* = 0`.
- **Read burst.** Host pushes 0xA5, 0x3C. Each read pulses `rd_n` low for 4 cycles → `data_out = 0xA5` then `0x3C`, each valid exactly `RD_LAT` cycles after the fall. `rxf_n` is high for `RECOVER` cycles after each rise, then stays 1 when the FIFO is empty.
- **Write fill.**
  - Write 16 bytes 0x00–0x0F with `host_rready = 0` → `txe_n = 1` after the 16th byte.
  - A 17th `wr_n` pulse (0xFF) sets `err_wr`, and 0xFF never appears on the host side.
  - Draining the TX FIFO yields 0x00–0x0F in order.
- **Protocol errors.**
  - `rd_n` fall with RX empty → `err_rd = 1`, `data_oe` stays 0.
  - `wr_n` low while `data_oe = 1` → `err_bus = 1`.
- **Concurrency and reset.**
  - Host push into an RX FIFO holding 15 bytes in the same cycle as an FPGA pop → count stays 15.
  - Simultaneous RX read and TX write complete independently.
  - Reset asserted in `R_DRIVE` → `data_oe = 0` immediately, and there is no pop after release.
